// File: rtl/raster_pkg.sv
// Shared definitions for the rectangle rasterizer: FSM state type and default
// geometry. Clipping is compiled in with RASTER_CLIP_EN (see raster_clip.sv).
package raster_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WAIT_NO_DATA = 3'd1,
        ST_SETUP        = 3'd2,
        ST_DRAW         = 3'd3,
        ST_DONE         = 3'd4
    } raster_state_t;

    localparam int DEF_COORD_W  = 11;
    localparam int DEF_COLOR_W  = 16;
    localparam int DEF_ADDR_W   = 24;
    localparam int DEF_STRIDE   = 800;
    localparam int DEF_SCREEN_W = 800;
    localparam int DEF_SCREEN_H = 480;

endpackage

// File: rtl/rect_rasterizer_if.sv
// Pixel-addressed frame-buffer write port with waitrequest back-pressure.
interface rect_rasterizer_if #(
    parameter int ADDR_W  = 24,
    parameter int COLOR_W = 16
);
    logic [ADDR_W-1:0]  mem_address;
    logic [COLOR_W-1:0] mem_writedata;
    logic               mem_write;
    logic               mem_waitrequest;

    modport master (
        output mem_address,
        output mem_writedata,
        output mem_write,
        input  mem_waitrequest
    );

    modport slave (
        input  mem_address,
        input  mem_writedata,
        input  mem_write,
        output mem_waitrequest
    );
endinterface

// File: rtl/raster_clip.sv
// Combinational clamp of a rectangle to the visible screen plus empty test.
// Only instantiated when RASTER_CLIP_EN is defined.
module raster_clip #(
    parameter int COORD_W  = 11,
    parameter int SCREEN_W = 800,
    parameter int SCREEN_H = 480
) (
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] x1_clip,
    output logic [COORD_W-1:0] y1_clip,
    output logic               empty
);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(SCREEN_H - 1);

    always_comb begin
        x1_clip = (x1 > X_MAX) ? X_MAX : x1;
        y1_clip = (y1 > Y_MAX) ? Y_MAX : y1;
        // An origin past the screen edge would otherwise survive the clamp
        // only through the x0>x1 test; keep it explicit.
        empty   = (x0 > X_MAX) || (y0 > Y_MAX) || (x0 > x1_clip) || (y0 > y1_clip);
    end
endmodule

// File: rtl/rect_rasterizer.sv
// Filled axis-aligned rectangle rasterizer: four-phase data_ready/busy command
// intake, row-major pixel writes. Optional screen clipping via RASTER_CLIP_EN.
module rect_rasterizer
    import raster_pkg::*;
#(
    parameter int COORD_W  = DEF_COORD_W,
    parameter int COLOR_W  = DEF_COLOR_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int STRIDE   = DEF_STRIDE,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               data_ready,
    output logic               busy,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COLOR_W-1:0] color,
    rect_rasterizer_if.master  mem
);
    raster_state_t      state_reg, state_next;
    logic               busy_reg, busy_next;
    logic [ADDR_W-1:0]  base_reg, base_next;
    logic [COORD_W-1:0] x0_reg, x0_next;
    logic [COORD_W-1:0] y0_reg, y0_next;
    logic [COORD_W-1:0] x1_reg, x1_next;
    logic [COORD_W-1:0] y1_reg, y1_next;
    logic [COLOR_W-1:0] color_reg, color_next;
    logic [COORD_W-1:0] x_reg, x_next;
    logic [COORD_W-1:0] y_reg, y_next;
    logic [ADDR_W-1:0]  row_addr_reg, row_addr_next;

    logic [COORD_W-1:0] x1_eff;
    logic [COORD_W-1:0] y1_eff;
    logic               rect_empty;

`ifdef RASTER_CLIP_EN
    raster_clip #(
        .COORD_W  (COORD_W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_clip (
        .x0      (x0_reg),
        .y0      (y0_reg),
        .x1      (x1_reg),
        .y1      (y1_reg),
        .x1_clip (x1_eff),
        .y1_clip (y1_eff),
        .empty   (rect_empty)
    );
`else
    assign x1_eff     = x1_reg;
    assign y1_eff     = y1_reg;
    assign rect_empty = (x0_reg > x1_reg) || (y0_reg > y1_reg);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            busy_reg     <= 1'b0;
            base_reg     <= '0;
            x0_reg       <= '0;
            y0_reg       <= '0;
            x1_reg       <= '0;
            y1_reg       <= '0;
            color_reg    <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            row_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            busy_reg     <= busy_next;
            base_reg     <= base_next;
            x0_reg       <= x0_next;
            y0_reg       <= y0_next;
            x1_reg       <= x1_next;
            y1_reg       <= y1_next;
            color_reg    <= color_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            row_addr_reg <= row_addr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        busy_next     = busy_reg;
        base_next     = base_reg;
        x0_next       = x0_reg;
        y0_next       = y0_reg;
        x1_next       = x1_reg;
        y1_next       = y1_reg;
        color_next    = color_reg;
        x_next        = x_reg;
        y_next        = y_reg;
        row_addr_next = row_addr_reg;

        case (state_reg)
            ST_IDLE: begin
                if (data_ready) begin
                    base_next  = base_addr;
                    x0_next    = x0;
                    y0_next    = y0;
                    x1_next    = x1;
                    y1_next    = y1;
                    color_next = color;
                    busy_next  = 1'b1;
                    state_next = ST_WAIT_NO_DATA;
                end
            end
            ST_WAIT_NO_DATA: begin
                if (!data_ready) state_next = ST_SETUP;
            end
            ST_SETUP: begin
                // Clipped corners are stored so DRAW compares against them only.
                x1_next = x1_eff;
                y1_next = y1_eff;
                if (rect_empty) begin
                    state_next = ST_DONE;
                end else begin
                    row_addr_next = base_reg + ADDR_W'(ADDR_W'(y0_reg) * ADDR_W'(STRIDE));
                    x_next        = x0_reg;
                    y_next        = y0_reg;
                    state_next    = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (!mem.mem_waitrequest) begin
                    if (x_reg < x1_reg) begin
                        x_next = x_reg + 1'b1;
                    end else if (y_reg < y1_reg) begin
                        x_next        = x0_reg;
                        y_next        = y_reg + 1'b1;
                        row_addr_next = row_addr_reg + ADDR_W'(STRIDE);
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
            default: begin
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Write request decoded straight from state so reset drops it at once;
    // address and data come from registers and therefore hold under stall.
    assign busy              = busy_reg;
    assign mem.mem_write     = (state_reg == ST_DRAW);
    assign mem.mem_address   = row_addr_reg + ADDR_W'(x_reg);
    assign mem.mem_writedata = color_reg;

endmodule

// File: tb/tb_rect_rasterizer.sv
// Randomized self-checking bench for rect_rasterizer against a loop-based
// pixel-list model; honours RASTER_CLIP_EN like the design.
module tb_rect_rasterizer;
    localparam int COORD_W  = 11;
    localparam int COLOR_W  = 16;
    localparam int ADDR_W   = 24;
    localparam int STRIDE   = 800;
    localparam int SCREEN_W = 800;
    localparam int SCREEN_H = 480;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               data_ready = 1'b0;
    logic               busy;
    logic [ADDR_W-1:0]  base_addr = '0;
    logic [COORD_W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [COLOR_W-1:0] color = '0;

    int checks = 0;
    int errors = 0;

    rect_rasterizer_if #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) mem_if ();

    rect_rasterizer #(
        .COORD_W(COORD_W), .COLOR_W(COLOR_W), .ADDR_W(ADDR_W),
        .STRIDE(STRIDE), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .data_ready (data_ready),
        .busy       (busy),
        .base_addr  (base_addr),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .color      (color),
        .mem        (mem_if.master)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Expected pixel addresses in row-major order, modulo 2^ADDR_W.
    task automatic build_model(input logic [ADDR_W-1:0] b,
                               input int ax0, input int ay0, input int ax1, input int ay1,
                               output logic [ADDR_W-1:0] q[$]);
        int ex1 = ax1;
        int ey1 = ay1;
        bit empty = 1'b0;
        longint a;
        q = {};
`ifdef RASTER_CLIP_EN
        if (ax0 >= SCREEN_W || ay0 >= SCREEN_H) empty = 1'b1;
        if (ex1 > SCREEN_W - 1) ex1 = SCREEN_W - 1;
        if (ey1 > SCREEN_H - 1) ey1 = SCREEN_H - 1;
`endif
        if (!empty) begin
            for (int yy = ay0; yy <= ey1; yy++) begin
                for (int xx = ax0; xx <= ex1; xx++) begin
                    a = longint'(b) + longint'(yy) * STRIDE + longint'(xx);
                    q.push_back(ADDR_W'(a & ((64'd1 << ADDR_W) - 1)));
                end
            end
        end
    endtask

    // Called at a negedge; stall_mode 0..100 is a stall percentage, 101 means
    // stall exactly three cycles on the second write.
    task automatic run_rect(input logic [ADDR_W-1:0] b,
                            input int ax0, input int ay0, input int ax1, input int ay1,
                            input logic [COLOR_W-1:0] c, input int stall_mode, input bit reraise);
        logic [ADDR_W-1:0] exp_q[$];
        logic [ADDR_W-1:0] prev_addr = '0;
        int n, hold, cyc, idx, first, last, fall, budget, stall_cnt;
        bit prev_stall, wr;
        build_model(b, ax0, ay0, ax1, ay1, exp_q);
        n = exp_q.size();
        budget = 4 * n + 40;
        base_addr = b; x0 = COORD_W'(ax0); y0 = COORD_W'(ay0);
        x1 = COORD_W'(ax1); y1 = COORD_W'(ay1); color = c;
        data_ready = 1'b1;
        @(negedge clock);
        check_val("busy_rise", busy, 1);
        hold = $urandom_range(0, 2);
        repeat (hold) begin
            @(negedge clock);
            check_val("hold_busy", busy, 1);
            check_val("hold_no_write", mem_if.mem_write, 0);
        end
        data_ready = 1'b0;
        cyc = 0; idx = 0; first = -1; last = -1; fall = -1;
        prev_stall = 1'b0; stall_cnt = 0;
        while (fall < 0 && cyc < budget) begin
            @(negedge clock);
            cyc++;
            if (reraise && cyc == 3) begin
                data_ready = 1'b1;
                base_addr = ADDR_W'($urandom);
                x0 = COORD_W'($urandom_range(0, 50)); y0 = COORD_W'($urandom_range(0, 50));
                x1 = COORD_W'($urandom_range(0, 50)); y1 = COORD_W'($urandom_range(0, 50));
                color = COLOR_W'($urandom);
            end
            if (!busy) begin
                fall = cyc;
            end else if (mem_if.mem_write) begin
                if (first < 0) first = cyc;
                if (prev_stall) begin
                    check_val("stall_hold_addr", mem_if.mem_address, prev_addr);
                    check_val("stall_hold_data", mem_if.mem_writedata, c);
                end
                if (stall_mode == 101) begin
                    wr = (idx == 1 && stall_cnt < 3);
                    if (wr) stall_cnt++;
                end else begin
                    wr = ($urandom_range(0, 99) < stall_mode);
                end
                mem_if.mem_waitrequest = wr;
                if (!wr) begin
                    if (idx < n) begin
                        check_val("pix_addr", mem_if.mem_address, exp_q[idx]);
                        check_val("pix_data", mem_if.mem_writedata, c);
                    end else begin
                        check_val("extra_write", idx, n - 1);
                    end
                    idx++;
                    last = cyc;
                end
                prev_stall = wr;
                prev_addr = mem_if.mem_address;
            end
        end
        mem_if.mem_waitrequest = 1'b0;
        if (fall < 0) check_val("timeout_busy_fall", 0, 1);
        check_val("write_count", idx, n);
        if (n > 0) begin
            check_val("first_write_latency", first, 2);
            check_val("busy_fall_after_last", fall, last + 2);
        end else begin
            check_val("empty_busy_fall", fall, 3);
        end
        $display("rect base=%06h (%0d,%0d)-(%0d,%0d) color=%04h stall=%0d writes=%0d/%0d cycles=%0d",
                 b, ax0, ay0, ax1, ay1, c, stall_mode, idx, n, cyc);
    endtask

    initial begin
        int rx0, ry0, w, h, tries;
        mem_if.mem_waitrequest = 1'b0;
        repeat (2) @(negedge clock);
        check_val("rst_busy", busy, 0);
        check_val("rst_mem_write", mem_if.mem_write, 0);
        check_val("rst_mem_address", mem_if.mem_address, 0);
        check_val("rst_mem_writedata", mem_if.mem_writedata, 0);
        reset_n = 1'b1;
        @(negedge clock);

        run_rect(24'h001000, 2, 3, 4, 4, 16'hF800, 0, 1'b0);
        run_rect(24'h001000, 2, 3, 4, 4, 16'hF800, 101, 1'b0);
        run_rect(24'h001000, 5, 3, 4, 4, 16'h07E0, 0, 1'b0);
        run_rect(24'h000000, 798, 479, 900, 600, 16'h001F, 0, 1'b0);
        // Second command waits until busy has dropped, then starts immediately.
        run_rect(24'h020000, 10, 10, 13, 11, 16'h1234, 20, 1'b1);
        run_rect(24'h030000, 1, 1, 2, 2, 16'h4321, 0, 1'b0);
        run_rect(24'hFFFF00, 790, 470, 795, 472, 16'hABCD, 30, 1'b0);

        for (int i = 0; i < 20; i++) begin
            rx0 = $urandom_range(0, 820);
            ry0 = $urandom_range(0, 490);
            w = $urandom_range(0, 6);
            h = $urandom_range(0, 4);
            run_rect(ADDR_W'($urandom), rx0, ry0, rx0 + w - 1, ry0 + h - 1,
                     COLOR_W'($urandom), $urandom_range(0, 40), 1'b0);
        end

        // Reset during DRAW of a 10x10 rectangle.
        base_addr = 24'h004000; x0 = 11'd0; y0 = 11'd0; x1 = 11'd9; y1 = 11'd9;
        color = 16'h5555; data_ready = 1'b1;
        @(negedge clock);
        data_ready = 1'b0;
        tries = 0;
        while (!mem_if.mem_write && tries < 10) begin
            @(negedge clock);
            tries++;
        end
        check_val("reset_test_draw_started", mem_if.mem_write, 1);
        repeat (15) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_val("midreset_mem_write", mem_if.mem_write, 0);
        check_val("midreset_busy", busy, 0);
        check_val("midreset_mem_address", mem_if.mem_address, 0);
        $display("reset asserted mid-draw: mem_write=%0b busy=%0b", mem_if.mem_write, busy);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_rect(24'h004000, 0, 0, 9, 9, 16'h5555, 10, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 expected=0");
        $fatal(1);
    end
endmodule
